port_in_fifo: RTL and testbench

- Input-port buffer that sits directly upstream of the register file's port input.
- Accepts words from an external device with a valid/ready handshake and stores them in a small FIFO.
- Presents the head word on the port bus, which the register file samples into its port register on every cycle it is not being written.
- The CPU pulses an acknowledge once it has consumed the current port word; the FIFO then advances to the next word.

---
 rtl/port_in_fifo.sv | 183 ++++++++++++++++++
 tb/tb_port_in_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/port_in_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// port_in_fifo
//
// Input-port buffer in front of the register file's port input. An external
// device pushes words with a valid/ready handshake; the oldest stored word is
// presented combinationally on `port` (first-word-fall-through) so the register
// file can sample it on any cycle it is not being written. The CPU pulses
// `rd_ack` once it has consumed that word and the buffer advances.
//
// Parameters:
//   WIDTH  data word width in bits (matches the register-file width)
//   DEPTH  number of entries; power of 2, at least 2
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst_n       synchronous active-low reset; clears pointers and count
//   ext_data    word offered by the external device
//   ext_valid   external device is offering ext_data
//   ext_ready   buffer can accept a word (!full)
//   rd_ack      CPU consumed the current port word (pop request)
//   port        head word, 0 when empty
//   port_valid  port holds a real buffered word (!empty)
//   full        count == DEPTH
//   empty       count == 0
//   count       number of stored words
//
// Optional feature, enabled by defining the macro PORT_IN_ERR_EN:
//   err_ovf     sticky: a word was offered while full (the word is dropped)
//   err_udf     sticky: rd_ack was seen while empty
//   Both flags clear only on reset. Without the macro these ports do not exist
//   and overflow/underflow attempts are silently ignored.
//
// Every output is derived from registered state only; there is no
// combinational path from ext_valid or rd_ack to any output.
// -----------------------------------------------------------------------------
module port_in_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           ext_data,
    input  logic                       ext_valid,
    output logic                       ext_ready,
    input  logic                       rd_ack,
    output logic [WIDTH-1:0]           port,
    output logic                       port_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PORT_IN_ERR_EN
    ,
    output logic                       err_ovf,
    output logic                       err_udf
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    // -------------------------------------------------------------------------
    // Status, decoded from the registered count only
    // -------------------------------------------------------------------------
    logic full_w;
    logic empty_w;

    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    // A full buffer refuses a push even when a pop happens in the same cycle;
    // the freed slot is offered on the following cycle. This keeps ext_ready
    // independent of rd_ack.
    logic push;
    logic pop;

    assign push = ext_valid && !full_w;
    assign pop  = rd_ack && !empty_w;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;   // idle, or push and pop together
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset; stale entries are unreachable because
    // port is forced to 0 while empty, and omitting the reset lets the array
    // map onto plain storage cells.
    // A push during reset may still write an entry; it is never read because
    // the pointers and count are cleared in that same cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ext_data;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign full       = full_w;
    assign empty      = empty_w;
    assign ext_ready  = !full_w;
    assign port_valid = !empty_w;
    assign count      = count_q;

    // First-word-fall-through: the head entry is read directly, so a pop edge
    // makes the next word visible in the same cycle the count drops.
    assign port = empty_w ? '0 : mem_q[rd_ptr_q];

`ifdef PORT_IN_ERR_EN
    // -------------------------------------------------------------------------
    // Sticky error flags
    // -------------------------------------------------------------------------
    logic err_ovf_q;
    logic err_udf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            if (ext_valid && full_w) begin
                err_ovf_q <= 1'b1;
            end
            if (rd_ack && empty_w) begin
                err_udf_q <= 1'b1;
            end
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
`endif

endmodule

// File: tb/tb_port_in_fifo.sv
`timescale 1ns/1ps
module tb_port_in_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] ext_data;
    logic             ext_valid;
    logic             ext_ready;
    logic             rd_ack;
    logic [WIDTH-1:0] port;
    logic             port_valid;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
`ifdef PORT_IN_ERR_EN
    logic             err_ovf;
    logic             err_udf;
`endif

    int total = 0;
    int bad   = 0;

    // Scoreboard: words the bench expects the FIFO to hold, oldest first.
    logic [WIDTH-1:0] sb[$];

    port_in_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ext_data   (ext_data),
        .ext_valid  (ext_valid),
        .ext_ready  (ext_ready),
        .rd_ack     (rd_ack),
        .port       (port),
        .port_valid (port_valid),
        .full       (full),
        .empty      (empty),
        .count      (count)
`ifdef PORT_IN_ERR_EN
        ,
        .err_ovf    (err_ovf),
        .err_udf    (err_udf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given inputs; the scoreboard follows the handshake
    // rules (push only when not full, pop only when not empty).
    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic a);
        logic acc;
        logic pp;
        acc = v && (sb.size() < DEPTH);
        pp  = a && (sb.size() > 0);
        ext_valid = v;
        ext_data  = d;
        rd_ack    = a;
        @(posedge clk);
        #1;
        if (pp)  void'(sb.pop_front());
        if (acc) sb.push_back(d);
        ext_valid = 1'b0;
        ext_data  = '0;
        rd_ack    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ext_valid = 1'b0; ext_data = '0; rd_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        total++; if (count !== 0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
        total++; if (ext_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ext_ready); end
        total++; if (port !== 8'h00) begin bad++; $display("FAIL reset_port: got %h want 00", port); end
        total++; if (port_valid !== 1'b0) begin bad++; $display("FAIL reset_pvalid: got %b want 0", port_valid); end
`ifdef PORT_IN_ERR_EN
        total++; if (err_ovf !== 1'b0 || err_udf !== 1'b0) begin bad++; $display("FAIL reset_err: got %b%b want 00", err_ovf, err_udf); end
`endif
    endtask

    task automatic test_basic();
        drive(1'b1, 8'h11, 1'b0);
        total++; if (port !== 8'h11) begin bad++; $display("FAIL basic_first_word: got %h want 11", port); end
        total++; if (port_valid !== 1'b1) begin bad++; $display("FAIL basic_pvalid: got %b want 1", port_valid); end
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b1, 8'h33, 1'b0);
        total++; if (count !== 3) begin bad++; $display("FAIL basic_count: got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            total++; if (port !== sb[0]) begin bad++; $display("FAIL basic_pop%0d: got %h want %h", i, port, sb[0]); end
            drive(1'b0, '0, 1'b1);
        end
        total++; if (port !== 8'h00) begin bad++; $display("FAIL basic_drained_port: got %h want 00", port); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL basic_drained_empty: got %b want 1", empty); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), 1'b0);
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL full_flag: got %b want 1", full); end
        total++; if (ext_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", ext_ready); end
        drive(1'b1, 8'hFF, 1'b0);
        drive(1'b1, 8'hFF, 1'b0);
        total++; if (count !== 4) begin bad++; $display("FAIL full_ovf_count: got %0d want 4", count); end
        total++; if (port !== 8'hA0) begin bad++; $display("FAIL full_ovf_head: got %h want a0", port); end
`ifdef PORT_IN_ERR_EN
        total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL full_err_ovf: got %b want 1", err_ovf); end
`endif
        // Pop while full: the offered word must not be taken this cycle.
        drive(1'b1, 8'hEE, 1'b1);
        total++; if (count !== 3) begin bad++; $display("FAIL full_pop_no_push: got %0d want 3", count); end
        total++; if (ext_ready !== 1'b1) begin bad++; $display("FAIL full_slot_freed: got %b want 1", ext_ready); end
        drive(1'b1, 8'hEF, 1'b0);
        total++; if (count !== 4) begin bad++; $display("FAIL full_refill: got %0d want 4", count); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (port !== sb[0]) begin bad++; $display("FAIL full_drain%0d: got %h want %h", i, port, sb[0]); end
            drive(1'b0, '0, 1'b1);
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drained: got %b want 1", empty); end
    endtask

    task automatic test_simul();
        drive(1'b1, 8'h61, 1'b0);
        drive(1'b1, 8'h62, 1'b0);
        total++; if (count !== 2) begin bad++; $display("FAIL simul_pre_count: got %0d want 2", count); end
        total++; if (port !== 8'h61) begin bad++; $display("FAIL simul_pre_head: got %h want 61", port); end
        drive(1'b1, 8'h55, 1'b1);
        total++; if (count !== 2) begin bad++; $display("FAIL simul_count: got %0d want 2", count); end
        total++; if (port !== 8'h62) begin bad++; $display("FAIL simul_head: got %h want 62", port); end
        for (int i = 0; i < 2; i++) begin
            total++; if (port !== sb[0]) begin bad++; $display("FAIL simul_drain%0d: got %h want %h", i, port, sb[0]); end
            drive(1'b0, '0, 1'b1);
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL simul_drained: got %b want 1", empty); end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] next_exp;
        next_exp = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            logic a;
            a = (sb.size() >= 2);
            if (a) begin
                total++; if (port !== next_exp) begin bad++; $display("FAIL wrap_order: got %h want %h", port, next_exp); end
                next_exp++;
            end
            drive(1'b1, 8'(i), a);
            total++; if (count > 3) begin bad++; $display("FAIL wrap_count: got %0d want <=3", count); end
        end
        while (sb.size() > 0) begin
            total++; if (port !== next_exp) begin bad++; $display("FAIL wrap_tail: got %h want %h", port, next_exp); end
            next_exp++;
            drive(1'b0, '0, 1'b1);
        end
        total++; if (next_exp !== 8'h0B) begin bad++; $display("FAIL wrap_total: got %h want 0b", next_exp); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty: got %b want 1", empty); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'h71, 1'b0);
        drive(1'b1, 8'h72, 1'b0);
        drive(1'b1, 8'h73, 1'b0);
        total++; if (count !== 3) begin bad++; $display("FAIL mid_pre_count: got %0d want 3", count); end
`ifdef PORT_IN_ERR_EN
        total++; if (err_udf !== 1'b0) begin bad++; $display("FAIL mid_pre_udf: got %b want 0", err_udf); end
`endif
        rst_n = 1'b0; ext_valid = 1'b1; ext_data = 8'h77; rd_ack = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1; ext_valid = 1'b0; ext_data = '0; rd_ack = 1'b0;
        sb.delete();
        total++; if (count !== 0) begin bad++; $display("FAIL mid_count: got %0d want 0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL mid_empty: got %b want 1", empty); end
        total++; if (port !== 8'h00) begin bad++; $display("FAIL mid_port: got %h want 00", port); end
`ifdef PORT_IN_ERR_EN
        total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL mid_ovf_cleared: got %b want 0", err_ovf); end
`endif
        drive(1'b0, '0, 1'b1);
        total++; if (count !== 0) begin bad++; $display("FAIL udf_count: got %0d want 0", count); end
        total++; if (empty !== 1'b1 || port_valid !== 1'b0) begin bad++; $display("FAIL udf_status: got empty=%b pvalid=%b want 1/0", empty, port_valid); end
        total++; if (port !== 8'h00) begin bad++; $display("FAIL udf_port: got %h want 00", port); end
`ifdef PORT_IN_ERR_EN
        total++; if (err_udf !== 1'b1) begin bad++; $display("FAIL udf_flag: got %b want 1", err_udf); end
`endif
        // The FIFO must still work normally after the underflow attempt.
        drive(1'b1, 8'h99, 1'b0);
        total++; if (port !== 8'h99) begin bad++; $display("FAIL post_udf_push: got %h want 99", port); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_simul();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
